s_mem_arbiter: RTL

Round-robin arbiter and sequencer for the single-port 256x8 S-memory shared by the RC4 stages (0 = S initialisation, 1 = KSA swap controller, 2 = PRGA/decrypt).
- Replaces the top-level selector mux.
- Grants exclusive, optionally locked ownership of the memory port, so multi-access sequences (read i, read j, write i, write j) are atomic.
- Returns read data with a per-requester valid strobe.

---
 rtl/s_mem_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/s_mem_arbiter.sv
// Round-robin owner arbiter for the shared 256x8 S-memory port.
// Grants are registered, optionally locked, and reads return one cycle later.
module s_mem_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ-1:0]    wren_in,
  input  logic [N_REQ*AW-1:0] addr_in,
  input  logic [N_REQ*DW-1:0] data_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic [AW-1:0]       mem_address,
  output logic [DW-1:0]       mem_data,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          found;
  int            idx;

  // First requester after the last owner, wrapping modulo N_REQ.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      rvalid <= '0;
      last   <= IW'(N_REQ - 1);
    end else begin
      rvalid <= req & gnt & ~wren_in;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt   <= N_REQ'(1) << pick;
            last  <= pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!req[last] && !lock[last]) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // last doubles as the owner index; while idle it keeps the old address.
  assign mem_address = addr_in[last*AW +: AW];
  assign mem_data    = data_in[last*DW +: DW];
  assign mem_wren    = |(wren_in & req & gnt);
  assign rdata       = mem_q;
  assign busy        = |gnt;

endmodule
